npu: RTL and testbench

Small fixed-point neural processing unit computing one fully connected layer, y = sat(shift(W·x + b)) with optional ReLU, on signed 8-bit data. It sits as a memory-mapped compute slave in the CLOCK_100 domain. A host loads inputs, weights and biases, pulses start, waits for done, then reads the results.

---
 rtl/npu_pkg.sv | 41 ++++
 rtl/npu_mac.sv | 38 +++
 rtl/npu.sv | 134 +++++++++++++
 tb/tb_npu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared sizes, FSM state type, operand address map and saturation helper for npu.
// Compile-time option NPU_RELU_EN (see npu.sv) clamps negative results to zero.
package npu_pkg;

  localparam int N_IN   = 8;
  localparam int N_OUT  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int SHIFT  = 4;
  localparam int ADDR_W = 6;

  localparam int J_W = $clog2(N_OUT);
  localparam int I_W = $clog2(N_IN);

  localparam int X_BASE = 0;
  localparam int W_BASE = N_IN;
  localparam int B_BASE = N_IN + N_OUT * N_IN;
  localparam int N_OPS  = B_BASE + N_OUT;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BIAS = 3'd1,
    MAC  = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Clamp a signed accumulator value into the signed 8-bit result range.
  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v > 24'sd127) begin
      r = 8'h7F;
    end else if (v < -24'sd128) begin
      r = 8'h80;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/npu_mac.sv
// Signed multiply-accumulate datapath for one neuron, with bias preload and
// a shift/saturate view of the accumulator for write-back.
module npu_mac
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_clr,
  input  logic              acc_load,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    acc_r;
  logic signed [ACC_W-1:0]    shifted_s;

  assign prod_s    = $signed(x) * $signed(w);
  assign shifted_s = acc_r >>> SHIFT;
  assign result    = saturate(shifted_s);

  // Accumulator: clear, bias preload, or add the sign-extended product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (acc_clr) begin
      acc_r <= '0;
    end else if (acc_load) begin
      acc_r <= {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    end else if (acc_en) begin
      acc_r <= acc_r + {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
    end
  end

endmodule

// File: rtl/npu.sv
// Fully connected layer engine: operand store, sequencing FSM and result registers.
// Define NPU_RELU_EN to clamp negative saturated results to zero at write-back.
module npu
  import npu_pkg::*;
(
  input  logic              CLOCK_100,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [J_W-1:0]    rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  state_t            state_r, state_nx_s;
  logic [J_W-1:0]    j_r;
  logic [I_W-1:0]    i_r;
  logic [DATA_W-1:0] ops_r [N_OPS];
  logic [DATA_W-1:0] y_r   [N_OUT];
  logic              busy_r, done_r;
  logic              acc_clr_s, acc_load_s, acc_en_s, y_we_s, wr_ok_s;
  logic [ADDR_W-1:0] x_idx_s, w_idx_s, b_idx_s;
  logic [DATA_W-1:0] mac_res_s, y_nx_s;

  assign wr_ok_s = wr_en && ((state_r == IDLE) || (state_r == DONE))
                   && (wr_addr < ADDR_W'(N_OPS));

  assign x_idx_s = ADDR_W'(X_BASE) + ADDR_W'(i_r);
  assign w_idx_s = ADDR_W'(W_BASE) + ADDR_W'(j_r) * ADDR_W'(N_IN) + ADDR_W'(i_r);
  assign b_idx_s = ADDR_W'(B_BASE) + ADDR_W'(j_r);

  // Operand store: host writes land only while the engine is not computing.
  always_ff @(posedge CLOCK_100 or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_OPS; k++) ops_r[k] <= '0;
    end else if (wr_ok_s) begin
      ops_r[wr_addr] <= wr_data;
    end
  end

  npu_mac u_mac (
    .clk      (CLOCK_100),
    .rst_n    (reset),
    .acc_clr  (acc_clr_s),
    .acc_load (acc_load_s),
    .acc_en   (acc_en_s),
    .bias     (ops_r[b_idx_s]),
    .x        (ops_r[x_idx_s]),
    .w        (ops_r[w_idx_s]),
    .result   (mac_res_s)
  );

  // Next-state and datapath controls.
  always_comb begin
    state_nx_s = state_r;
    acc_clr_s  = 1'b0;
    acc_load_s = 1'b0;
    acc_en_s   = 1'b0;
    y_we_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_clr_s  = 1'b1;
          state_nx_s = BIAS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BIAS: begin
        acc_load_s = 1'b1;
        state_nx_s = MAC;
      end
      MAC: begin
        acc_en_s = 1'b1;
        if (i_r == I_W'(N_IN - 1)) state_nx_s = WB;
        else                       state_nx_s = MAC;
      end
      WB: begin
        y_we_s = 1'b1;
        if (j_r == J_W'(N_OUT - 1)) state_nx_s = DONE;
        else                        state_nx_s = BIAS;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, loop counters and status flags decoded from the next state.
  always_ff @(posedge CLOCK_100 or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      j_r     <= '0;
      i_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == BIAS) || (state_nx_s == MAC) || (state_nx_s == WB);
      done_r  <= (state_nx_s == DONE);
      case (state_r)
        IDLE:    if (start) j_r <= '0;
        BIAS:    i_r <= '0;
        MAC:     i_r <= i_r + I_W'(1);
        WB:      if (j_r != J_W'(N_OUT - 1)) j_r <= j_r + J_W'(1);
        default: i_r <= i_r;
      endcase
    end
  end

  always_comb begin
    y_nx_s = mac_res_s;
`ifdef NPU_RELU_EN
    if (mac_res_s[DATA_W-1]) y_nx_s = '0;
    else                     y_nx_s = mac_res_s;
`endif
  end

  // Result registers, written one neuron at a time.
  always_ff @(posedge CLOCK_100 or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_OUT; k++) y_r[k] <= '0;
    end else if (y_we_s) begin
      y_r[j_r] <= y_nx_s;
    end
  end

  assign rd_data = (32'(rd_addr) < N_OUT) ? y_r[rd_addr] : '0;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_npu.sv
// Directed self-checking bench for npu; expectations follow NPU_RELU_EN when defined.
module tb_npu;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = 6'd0;
  logic [7:0] wr_data = 8'd0;
  logic       start = 1'b0;
  logic [1:0] rd_addr = 2'd0;
  logic [7:0] rd_data;
  logic       busy, done;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef NPU_RELU_EN
  localparam logic [7:0] NEG1   = 8'h00;
  localparam logic [7:0] NEG128 = 8'h00;
`else
  localparam logic [7:0] NEG1   = 8'hFF;
  localparam logic [7:0] NEG128 = 8'h80;
`endif

  always #5 clk = ~clk;

  npu dut (
    .CLOCK_100 (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    wr_en = 1'b1;
    wr_addr = 6'(addr);
    wr_data = 8'(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_uniform(input int xv, input int wv, input int bv);
    for (int i = 0; i < 8; i++)  wr(i, xv);
    for (int k = 0; k < 32; k++) wr(8 + k, wv);
    for (int j = 0; j < 4; j++)  wr(40 + j, bv);
  endtask

  task automatic check_y(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int j = 0; j < 4; j++) begin
      rd_addr = 2'(j);
      #1;
      check($sformatf("%s y%0d", tag, j), rd_data, e[j]);
    end
    @(negedge clk);
  endtask

  // Starts a layer from an IDLE negedge and returns at the IDLE negedge after DONE.
  task automatic run(input string tag, input bit poke, input bit co_wr,
                     input int co_addr, input int co_data);
    int lat;
    int busy_cnt;
    start = 1'b1;
    if (co_wr) begin
      wr_en = 1'b1;
      wr_addr = 6'(co_addr);
      wr_data = 8'(co_data);
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke && lat == 10) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 6'd0;
        wr_data = 8'd100;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, " latency"}, lat, 40);
    check({tag, " busy cycles"}, busy_cnt, 40);
    check({tag, " busy in done"}, busy, 0);
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
    check({tag, " busy after"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check_y("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    load_uniform(1, 2, 0);
    run("pos", 1'b0, 1'b0, 0, 0);
    check_y("pos", 8'h01, 8'h01, 8'h01, 8'h01);

    load_uniform(127, 127, 0);
    run("sat", 1'b0, 1'b0, 0, 0);
    check_y("sat", 8'h7F, 8'h7F, 8'h7F, 8'h7F);

    load_uniform(1, -2, 0);
    run("neg1", 1'b0, 1'b0, 0, 0);
    check_y("neg1", NEG1, NEG1, NEG1, NEG1);

    load_uniform(127, -128, 0);
    run("negsat", 1'b0, 1'b0, 0, 0);
    check_y("negsat", NEG128, NEG128, NEG128, NEG128);

    load_uniform(0, 5, 0);
    wr(40, 16);
    wr(42, -16);
    run("bias", 1'b0, 1'b0, 0, 0);
    check_y("bias", 8'h01, 8'h00, NEG1, 8'h00);

    for (int i = 0; i < 8; i++) wr(i, i + 1);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 8; i++) wr(8 + j * 8 + i, j + 1);
    for (int j = 0; j < 4; j++) wr(40 + j, 0);
    run("index", 1'b0, 1'b0, 0, 0);
    check_y("index", 8'h02, 8'h04, 8'h06, 8'h09);

    load_uniform(1, 2, 0);
    run("wrstart", 1'b0, 1'b1, 40, 32);
    check_y("wrstart", 8'h03, 8'h01, 8'h01, 8'h01);

    wr(40, 0);
    run("busypoke", 1'b1, 1'b0, 0, 0);
    check_y("busypoke", 8'h01, 8'h01, 8'h01, 8'h01);
    run("b2b_a", 1'b0, 1'b0, 0, 0);
    run("b2b_b", 1'b0, 1'b0, 0, 0);
    check_y("b2b", 8'h01, 8'h01, 8'h01, 8'h01);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check_y("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    wr(40, 16);
    run("postrst", 1'b0, 1'b0, 0, 0);
    check_y("postrst", 8'h01, 8'h00, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
